ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port synchronous RAM (ramlpm wrapper: address, clock, data, wren, q) between two requesters, port 0 and port 1.
- Uses round-robin arbitration and issues at most one access per cycle.
- Read accesses are pipelined: each read's data returns tagged to the requester that issued it.
- Includes a bulk-clear sequencer that writes CLR_VALUE to every address; requesters are stalled while it runs.

Parameters:
- ADDR_W, 8, address width; the RAM depth is 2**ADDR_W words.
- DATA_W, 8, data width.
- RD_LAT, 1, RAM read latency in cycles, from the grant cycle to valid q. Legal range is 1..3.
- CLR_VALUE, 0, word written to every address during a clear.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clr_start  in  1  one-cycle pulse that requests a bulk clear.
- busy  out  1  high while the clear is running.
- r0_req  in  1  port 0 request; held until r0_gnt.
- r0_we  in  1  port 0 write enable (1 = write, 0 = read).
- r0_addr  in  ADDR_W  port 0 address.
- r0_wdata  in  DATA_W  port 0 write data.
- r0_gnt  out  1  port 0 request accepted this cycle.
- r0_rvalid  out  1  port 0 read data valid.
- r0_rdata  out  DATA_W  port 0 read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as port 0, for port 1.
- mem_address  out  ADDR_W  to RAM address.
- mem_data  out  DATA_W  to RAM data.
- mem_wren  out  1  to RAM wren.
- mem_q  in  DATA_W  from RAM q.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State is IDLE; busy=0; clear counter is 0.
  - The round-robin pointer last=1, so port 0 wins the first contention.
  - Tag pipeline is flushed; r0_rvalid=r1_rvalid=0; r0_rdata=r1_rdata=0.
- The state machine has two states, IDLE and CLEAR.
- IDLE grant logic (combinational within the cycle):
  - Only r0_req: r0_gnt=1.
  - Only r1_req: r1_gnt=1.
  - Both: grant the port not equal to last.
  - last updates at the clock edge to the port granted; it holds when no grant occurs.
  - At most one gnt is high in any cycle.
- Memory outputs:
  - With a grant, mem_address, mem_data and mem_wren equal the granted port's addr, wdata and we. The RAM samples them at the end of the grant cycle.
  - With no grant: mem_wren=0, mem_address=0, mem_data=0.
- Read return:
  - A read granted in cycle N produces rxx_rvalid=1 in cycle N+RD_LAT, with rxx_rdata=mem_q, on the issuing port only.
  - This uses an RD_LAT-deep shift register of {valid, port}.
  - Back-to-back reads give one rvalid per cycle, in order.
  - rdata holds its last value when rvalid=0.
  - Writes never produce rvalid.
- Read after write to the same address, granted on consecutive cycles: returns the new data. The RAM is configured old-data-on-same-cycle only; there is no same-cycle conflict because there is a single port.
- Entering CLEAR:
  - clr_start=1 in IDLE moves to CLEAR at the next edge.
  - Grants are still permitted in the clr_start cycle itself.
- In CLEAR:
  - busy=1; all gnt=0 whatever the requests.
  - mem_wren=1, mem_data=CLR_VALUE, mem_address=counter.
  - The counter runs 0 to 2**ADDR_W-1, one address per cycle.
  - After the cycle with the last address, the next state is IDLE and the counter returns to 0. The clear lasts exactly 2**ADDR_W cycles.
- Reads issued before the clear still return on schedule during CLEAR; the tag pipeline keeps shifting.
- clr_start during CLEAR is ignored; it does not restart or extend the clear.
- Requesters keep req asserted through CLEAR and are serviced in the first IDLE cycle under normal round-robin.
- Reset during CLEAR aborts immediately with no resume. Addresses not yet written keep their old contents.

Test Plan:
- Single read: preload addr 0x05=0x2A via r0 write; then r0 read addr 0x05 -> r0_gnt in cycle N, r0_rvalid=1 with r0_rdata=0x2A in N+1, r1_rvalid stays 0.
- Contention: r0_req and r1_req both held with reads of 0x10 and 0x11 after reset -> grant order r0, r1, r0, r1 on successive cycles; each rvalid arrives on the correct port with the correct data.
- Write/read interleave: r1 writes 0x33 to 0x07, then r0 reads 0x07 in the next cycle -> r0_rdata=0x33.
- Clear: fill all addresses with 0xFF, pulse clr_start with r0_req held -> busy=1 for exactly 256 cycles, no gnt during busy, r0 granted in the first cycle after busy falls; reads of 0x00, 0x80 and 0xFF return 0x00.
- Clear overlap: r1 read granted in the clr_start cycle -> r1_rvalid still arrives RD_LAT cycles later while busy=1; a second clr_start mid-clear does not extend busy beyond 256 cycles.
- Reset mid-clear: assert resetn=0 at counter 0x40 -> busy and rvalid drop immediately; after release, r0 wins contention first; address 0x80 still reads 0xFF.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter: round-robin sharing of one single-port RAM between two
// requesters, with tagged pipelined read return and a bulk-clear sequencer.
// Revision: 1.0
// ============================================================================
module ram_arbiter #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr_start,
  output logic              busy,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
  logic                r_last, w_last_nxt;
  logic                w_gnt0, w_gnt1;
  logic                w_rd_issue;
  logic [RD_LAT-1:0]   r_tag_v, r_tag_p;
  logic [DATA_W-1:0]   r_rdata0, r_rdata1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_last    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_last    <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_last_nxt    = r_last;
    w_gnt0        = 1'b0;
    w_gnt1        = 1'b0;
    busy          = 1'b0;
    mem_address   = '0;
    mem_data      = '0;
    mem_wren      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On contention the port that was not granted last time wins.
        w_gnt0 = r0_req & (~r1_req | r_last);
        w_gnt1 = r1_req & (~r0_req | ~r_last);
        if (w_gnt0) begin
          w_last_nxt  = 1'b0;
          mem_address = r0_addr;
          mem_data    = r0_wdata;
          mem_wren    = r0_we;
        end else if (w_gnt1) begin
          w_last_nxt  = 1'b1;
          mem_address = r1_addr;
          mem_data    = r1_wdata;
          mem_wren    = r1_we;
        end
        if (clr_start) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy        = 1'b1;
        mem_wren    = 1'b1;
        mem_data    = CLR_VALUE;
        mem_address = r_clr_cnt;
        if (r_clr_cnt == C_LAST_ADDR) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign r0_gnt     = w_gnt0;
  assign r1_gnt     = w_gnt1;
  assign w_rd_issue = (w_gnt0 & ~r0_we) | (w_gnt1 & ~r1_we);

  // Tag pipeline keeps shifting in every state so pre-clear reads still return.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tag_v <= '0;
      r_tag_p <= '0;
    end else begin
      r_tag_v[0] <= w_rd_issue;
      r_tag_p[0] <= w_gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign r0_rvalid = r_tag_v[RD_LAT-1] & ~r_tag_p[RD_LAT-1];
  assign r1_rvalid = r_tag_v[RD_LAT-1] &  r_tag_p[RD_LAT-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r0_rvalid) r_rdata0 <= mem_q;
      if (r1_rvalid) r_rdata1 <= mem_q;
    end
  end

  // Data is live while valid and otherwise holds the last returned word.
  assign r0_rdata = r0_rvalid ? mem_q : r_rdata0;
  assign r1_rdata = r1_rvalid ? mem_q : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// behavioural single-port RAM (one cycle read latency).
// Revision: 1.0
// ============================================================================
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clr_start;
  logic       busy;
  logic       r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [7:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_req, r1_we, r1_gnt, r1_rvalid;
  logic [7:0] r1_addr, r1_wdata, r1_rdata;
  logic [7:0] mem_address, mem_data, mem_q;
  logic       mem_wren;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram [0:255];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .CLR_VALUE(8'h00)) dut (
    .clock(clock), .resetn(resetn), .clr_start(clr_start), .busy(busy),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  // Solo write: granted in the same cycle, inputs idle at the next cycle start.
  task automatic wr(input int port, input logic [7:0] a, input logic [7:0] d);
    if (port == 0) drive0(1'b1, 1'b1, a, d); else drive1(1'b1, 1'b1, a, d);
    #3;
    chk("wr_gnt", (port == 0) ? r0_gnt : r1_gnt, 1);
    chk("wr_mem", {mem_wren, mem_address, mem_data}, {1'b1, a, d});
    cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Solo port 0 read: gnt in cycle N, rvalid/rdata in N+1.
  task automatic rd0(input logic [7:0] a, input logic [7:0] exp);
    drive0(1'b1, 1'b0, a, 8'h00);
    #3;
    chk("rd_gnt", {r0_gnt, r1_gnt, mem_wren, mem_address}, {1'b1, 1'b0, 1'b0, a});
    cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    #3;
    chk("rd_ret", {r0_rvalid, r1_rvalid, r0_rdata}, {1'b1, 1'b0, exp});
    cycle();
  endtask

  initial begin
    int busy_cycles;
    int fill_err;
    logic done;

    resetn = 1'b0;
    clr_start = 1'b0;
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
    chk("rst_mem", {mem_wren, mem_address, mem_data}, 0);
    cycle();
    resetn = 1'b1;

    // Single read
    wr(0, 8'h05, 8'h2A);
    rd0(8'h05, 8'h2A);
    #3;
    chk("rdata_hold", {r0_rvalid, r0_rdata}, {1'b0, 8'h2A});
    cycle();

    // Preload, then reset so contention starts from the reset pointer
    wr(0, 8'h10, 8'hA1);
    wr(0, 8'h11, 8'hB2);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    cycle();

    // Contention: r0 reads 0x10, r1 reads 0x11, both held
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        drive0(1'b1, 1'b0, 8'h10, 8'h00);
        drive1(1'b1, 1'b0, 8'h11, 8'h00);
      end else begin
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
      end
      #3;
      if (k < 4)
        chk($sformatf("cont_gnt%0d", k), {r0_gnt, r1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) begin
        if ((k - 1) % 2 == 0)
          chk($sformatf("cont_ret%0d", k), {r0_rvalid, r1_rvalid, r0_rdata}, {2'b10, 8'hA1});
        else
          chk($sformatf("cont_ret%0d", k), {r0_rvalid, r1_rvalid, r1_rdata}, {2'b01, 8'hB2});
      end
      cycle();
    end

    // Write then read on the next cycle from the other port
    wr(1, 8'h07, 8'h33);
    rd0(8'h07, 8'h33);

    // Fill the whole RAM with 0xFF
    fill_err = 0;
    for (int i = 0; i < 256; i++) begin
      drive0(1'b1, 1'b1, 8'(i), 8'hFF);
      #3;
      if (r0_gnt !== 1'b1) fill_err++;
      cycle();
    end
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    chk("fill_gnt_err", fill_err, 0);

    // Clear with an r1 read granted in the clr_start cycle
    clr_start = 1'b1;
    drive1(1'b1, 1'b0, 8'h80, 8'h00);
    #3;
    chk("clr0_gnt_busy", {r1_gnt, busy}, 2'b10);
    cycle();
    clr_start = 1'b0;
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    drive0(1'b1, 1'b0, 8'h00, 8'h00);
    #3;
    chk("clr1_busy", busy, 1);
    chk("clr1_r1ret", {r1_rvalid, r1_rdata}, {1'b1, 8'hFF});
    chk("clr1_nogrant", {r0_gnt, r1_gnt}, 0);
    chk("clr1_mem", {mem_wren, mem_address, mem_data}, {1'b1, 8'h00, 8'h00});
    busy_cycles = 1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cycle();
      clr_start = 1'b0;
      #3;
      if (!busy) begin
        done = 1'b1;
      end else begin
        busy_cycles++;
        chk("clr_nogrant", {r0_gnt, r1_gnt}, 0);
        chk("clr_addr", mem_address, busy_cycles - 1);
        if (busy_cycles == 100) clr_start = 1'b1;
      end
    end
    chk("clr_len", busy_cycles, 256);
    chk("post_clr_gnt", {r0_gnt, mem_wren, mem_address}, {1'b1, 1'b0, 8'h00});
    cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    #3;
    chk("post_clr_r00", {r0_rvalid, r0_rdata}, {1'b1, 8'h00});
    cycle();
    rd0(8'h80, 8'h00);
    rd0(8'hFF, 8'h00);

    // Reset in the middle of a clear
    wr(0, 8'h80, 8'hFF);
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    #3;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (busy === 1'b1 && mem_address === 8'h40) done = 1'b1;
      else begin
        cycle();
        #3;
      end
    end
    chk("mid_clr_reach", {busy, mem_address}, {1'b1, 8'h40});
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_drop", {busy, r0_rvalid, r1_rvalid}, 0);
    cycle();
    resetn = 1'b1;
    drive0(1'b1, 1'b0, 8'h80, 8'h00);
    drive1(1'b1, 1'b0, 8'h11, 8'h00);
    #3;
    chk("after_rst_first", {r0_gnt, r1_gnt, mem_address}, {2'b10, 8'h80});
    cycle();
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    #3;
    chk("after_rst_second", r1_gnt, 1);
    chk("after_rst_80", {r0_rvalid, r0_rdata}, {1'b1, 8'hFF});
    cycle();
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    #3;
    chk("after_rst_11", {r1_rvalid, r1_rdata}, {1'b1, 8'h00});
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
